// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Sequencing controller for a multi-cycle MIPS datapath. Each instruction
// moves through FETCH, DECODE, EXEC, MEM and WB. This block drives every
// write strobe and mux select. Field decode (register numbers, immediates,
// ALU op) is done elsewhere. This block only decides when those values are
// consumed.
//
// One memory port is shared between instruction fetch and data access.
//
// Configuration macro: MCTRL_PERF_EN adds the cyc_cnt/ret_cnt counters and
// their ports. When it is undefined the counters and ports are absent.
//
// Ports:
//   clk          in   system clock (rising edge)
//   rst          in   asynchronous active-high reset
//   opcode       in   IR[31:26]
//   funct        in   IR[5:0]
//   alu_zero     in   ALU zero flag (used in EXEC)
//   mem_ready    in   memory accepts the current request this cycle
//   mem_req      out  memory request
//   mem_we       out  memory write (qualified by mem_req)
//   mem_addr_sel out  0 = PC, 1 = ALU result
//   ir_wen       out  IR load strobe
//   pc_wen       out  PC load strobe
//   pc_sel       out  0 = PC+4, 1 = branch target, 2 = jump target
//   reg_wen      out  register file write strobe
//   reg_dst      out  0 = rd, 1 = rt, 2 = r31
//   reg_src      out  0 = ALU, 1 = memory data, 2 = PC+4
//   state        out  current FSM state
//   halted       out  high in HALT
//   illegal      out  one-cycle pulse on an unknown opcode
//   cyc_cnt      out  cycles spent outside HALT   (MCTRL_PERF_EN only)
//   ret_cnt      out  retired instructions        (MCTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int W_STATE = 3,
    parameter int W_PERF  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               ir_wen,
    output logic               pc_wen,
    output logic [1:0]         pc_sel,
    output logic               reg_wen,
    output logic [1:0]         reg_dst,
    output logic [1:0]         reg_src,
    output logic [W_STATE-1:0] state,
    output logic               halted,
`ifdef MCTRL_PERF_EN
    output logic [W_PERF-1:0]  cyc_cnt,
    output logic [W_PERF-1:0]  ret_cnt,
`endif
    output logic               illegal
);

    typedef enum logic [W_STATE-1:0] {
        S_FETCH  = W_STATE'(0),
        S_DECODE = W_STATE'(1),
        S_EXEC   = W_STATE'(2),
        S_MEM    = W_STATE'(3),
        S_WB     = W_STATE'(4),
        S_HALT   = W_STATE'(5)
    } state_t;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    state_t state_q, state_d;

    // Instruction class. The opcode comes straight from the IR. It stays
    // stable from DECODE until the next fetch is accepted, so EXEC, MEM and
    // WB can decode it again without keeping a copy.
    logic is_rtype, is_syscall, is_j, is_jal, is_beq, is_bne;
    logic is_alui, is_lw, is_sw, to_exec;

    always_comb begin
        is_rtype   = (opcode == OP_RTYPE);
        is_syscall = is_rtype && (funct == FN_SYSCALL);
        is_j       = (opcode == OP_J);
        is_jal     = (opcode == OP_JAL);
        is_beq     = (opcode == OP_BEQ);
        is_bne     = (opcode == OP_BNE);
        is_alui    = (opcode[5:3] == 3'b001);   // opcodes 0x08..0x0F
        is_lw      = (opcode == OP_LW);
        is_sw      = (opcode == OP_SW);
        to_exec    = (is_rtype && !is_syscall) || is_beq || is_bne ||
                     is_alui || is_lw || is_sw;
    end

    // Memory handshake: mem_req is the valid and mem_ready is the ready.
    // A transfer completes in a cycle where both are high. Once mem_req
    // rises, mem_req, mem_we and mem_addr_sel are held unchanged until that
    // cycle. mem_ready has no effect while mem_req is low.
    logic accept;
    logic illegal_int;

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_wen       = 1'b0;
        pc_wen       = 1'b0;
        pc_sel       = 2'd0;
        reg_wen      = 1'b0;
        reg_dst      = 2'd0;
        reg_src      = 2'd0;
        halted       = 1'b0;
        illegal_int  = 1'b0;
        accept       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                accept  = mem_ready;
                if (accept) begin
                    ir_wen  = 1'b1;
                    pc_wen  = 1'b1;
                    pc_sel  = 2'd0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_syscall) begin
                    state_d = S_HALT;
                end else if (is_j || is_jal) begin
                    pc_wen  = 1'b1;
                    pc_sel  = 2'd2;
                    if (is_jal) begin
                        reg_wen = 1'b1;
                        reg_dst = 2'd2;
                        reg_src = 2'd2;
                    end
                    state_d = S_FETCH;
                end else if (to_exec) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_int = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_beq || is_bne) begin
                    pc_sel  = 2'd1;
                    pc_wen  = is_beq ? alu_zero : !alu_zero;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_sw;
                accept       = mem_ready;
                if (accept) begin
                    state_d = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_wen = 1'b1;
                reg_dst = is_rtype ? 2'd0 : 2'd1;
                reg_src = is_lw ? 2'd1 : 2'd0;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // While reset is asserted, every output is forced low at once.
        // Without this, the FETCH request would appear during reset.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_wen       = 1'b0;
            pc_wen       = 1'b0;
            pc_sel       = 2'd0;
            reg_wen      = 1'b0;
            reg_dst      = 2'd0;
            reg_src      = 2'd0;
            halted       = 1'b0;
            illegal_int  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_int;

`ifdef MCTRL_PERF_EN
    logic [W_PERF-1:0] cyc_q, cyc_d;
    logic [W_PERF-1:0] ret_q, ret_d;
    logic              retire;

    // An instruction retires when it returns to FETCH from any later state.
    // An illegal opcode does not count as a retirement.
    always_comb begin
        retire = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                 (state_q != S_HALT) && !illegal_int;
        cyc_d  = (state_q != S_HALT) ? cyc_q + W_PERF'(1) : cyc_q;
        ret_d  = retire ? ret_q + W_PERF'(1) : ret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. The driver applies the inputs for one
// cycle and pushes the expected output vector for that cycle. A monitor
// compares the outputs with the expected vector on the falling edge.
//
// Vector layout (17 bits):
//   {state[2:0], mem_req, mem_we, mem_addr_sel, ir_wen, pc_wen, pc_sel[1:0],
//    reg_wen, reg_dst[1:0], reg_src[1:0], halted, illegal}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_wen;
    logic        pc_wen;
    logic [1:0]  pc_sel;
    logic        reg_wen;
    logic [1:0]  reg_dst;
    logic [1:0]  reg_src;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
`ifdef MCTRL_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
`endif

    multicycle_ctrl #(.W_STATE(3), .W_PERF(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct        (funct),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_wen       (ir_wen),
        .pc_wen       (pc_wen),
        .pc_sel       (pc_sel),
        .reg_wen      (reg_wen),
        .reg_dst      (reg_dst),
        .reg_src      (reg_src),
        .state        (state),
        .halted       (halted),
`ifdef MCTRL_PERF_EN
        .cyc_cnt      (cyc_cnt),
        .ret_cnt      (ret_cnt),
`endif
        .illegal      (illegal)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [16:0] exp_q[$];
    string       nm_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [16:0] ev(
        input logic [2:0] st, input logic req, input logic we, input logic asel,
        input logic irw, input logic pcw, input logic [1:0] pcs, input logic rw,
        input logic [1:0] rd, input logic [1:0] rs, input logic h, input logic ill);
        return {st, req, we, asel, irw, pcw, pcs, rw, rd, rs, h, ill};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            check(n, {15'd0, state, mem_req, mem_we, mem_addr_sel, ir_wen, pc_wen,
                      pc_sel, reg_wen, reg_dst, reg_src, halted, illegal},
                  {15'd0, e});
        end
    end

    // ---------------- expected vectors ----------------
    logic [16:0] V_ZERO, V_FACC, V_FWAIT, V_DEC, V_EX, V_HALT;

    initial begin
        V_ZERO  = ev(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        V_FACC  = ev(3'd0, 1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        V_FWAIT = ev(3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        V_DEC   = ev(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        V_EX    = ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0);
        V_HALT  = ev(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 0);
    end

    // ---------------- driver ----------------
    // Call this at posedge+1. It applies the inputs for one cycle, queues the
    // expected outputs, and returns at the next posedge+1.
    task automatic cyc(input logic rdy, input logic z, input logic [5:0] op,
                       input logic [5:0] fn, input logic [16:0] exp, input string nm);
        mem_ready = rdy;
        alu_zero  = z;
        opcode    = op;
        funct     = fn;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async_state", {29'd0, state}, 32'd0);
        check("rst_async_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        cyc(1, 0, 6'h00, 6'h00, V_ZERO, "in_reset");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 0, 6'h00, 6'h00, V_ZERO, "reset_outputs");
        cyc(0, 0, 6'h00, 6'h00, V_ZERO, "reset_outputs2");
        rst = 1'b0;

        // ADD: cycles in states 0,1,2,4, then back to 0.
        cyc(1, 0, 6'h00, 6'h20, V_FACC, "add_fetch");
        cyc(1, 0, 6'h00, 6'h20, V_DEC, "add_decode");
        cyc(1, 0, 6'h00, 6'h20, V_EX, "add_exec");
        cyc(1, 0, 6'h00, 6'h20, ev(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0), "add_wb");

        // LW with three wait cycles in MEM: eight cycles in total.
        cyc(1, 0, 6'h23, 6'h00, V_FACC, "lw_fetch");
        cyc(1, 0, 6'h23, 6'h00, V_DEC, "lw_decode");
        cyc(1, 0, 6'h23, 6'h00, V_EX, "lw_exec");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 6'h23, 6'h00, ev(3'd3, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0), "lw_mem_wait");
        cyc(1, 0, 6'h23, 6'h00, ev(3'd3, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0), "lw_mem_acc");
        cyc(1, 0, 6'h23, 6'h00, ev(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd1, 0, 0), "lw_wb");

        // BEQ with alu_zero=1 loads the PC. BNE with alu_zero=1 does not.
        cyc(1, 1, 6'h04, 6'h00, V_FACC, "beq_fetch");
        cyc(1, 1, 6'h04, 6'h00, V_DEC, "beq_decode");
        cyc(1, 1, 6'h04, 6'h00, ev(3'd2, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 0, 0), "beq_exec");
        cyc(1, 1, 6'h05, 6'h00, V_FACC, "bne_fetch");
        cyc(1, 1, 6'h05, 6'h00, V_DEC, "bne_decode");
        cyc(1, 1, 6'h05, 6'h00, ev(3'd2, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 2'd0, 0, 0), "bne_exec");
        // BNE with alu_zero=0 loads the PC.
        cyc(1, 0, 6'h05, 6'h00, V_FACC, "bne2_fetch");
        cyc(1, 0, 6'h05, 6'h00, V_DEC, "bne2_decode");
        cyc(1, 0, 6'h05, 6'h00, ev(3'd2, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 0, 0), "bne2_exec");

        // Fetch stall for one cycle, then JAL.
        cyc(0, 0, 6'h03, 6'h00, V_FWAIT, "jal_fetch_wait");
        cyc(1, 0, 6'h03, 6'h00, V_FACC, "jal_fetch");
        cyc(1, 0, 6'h03, 6'h00, ev(3'd1, 0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 2'd2, 0, 0), "jal_decode");
        // J
        cyc(1, 0, 6'h02, 6'h00, V_FACC, "j_fetch");
        cyc(1, 0, 6'h02, 6'h00, ev(3'd1, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 0), "j_decode");

        // SW with one wait cycle. mem_we is held during the wait.
        cyc(1, 0, 6'h2B, 6'h00, V_FACC, "sw_fetch");
        cyc(1, 0, 6'h2B, 6'h00, V_DEC, "sw_decode");
        cyc(1, 0, 6'h2B, 6'h00, V_EX, "sw_exec");
        cyc(0, 0, 6'h2B, 6'h00, ev(3'd3, 1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0), "sw_mem_wait");
        cyc(1, 0, 6'h2B, 6'h00, ev(3'd3, 1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0), "sw_mem_acc");

        // ADDI (I-type ALU) writes back to rt.
        cyc(1, 0, 6'h08, 6'h00, V_FACC, "addi_fetch");
        cyc(1, 0, 6'h08, 6'h00, V_DEC, "addi_decode");
        cyc(1, 0, 6'h08, 6'h00, V_EX, "addi_exec");
        cyc(1, 0, 6'h08, 6'h00, ev(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0), "addi_wb");

        // Illegal opcode, then SYSCALL, then twenty cycles in HALT.
        cyc(1, 0, 6'h3F, 6'h00, V_FACC, "ill_fetch");
        cyc(1, 0, 6'h3F, 6'h00, ev(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1), "ill_decode");
        cyc(1, 0, 6'h00, 6'h0C, V_FACC, "sys_fetch");
        cyc(1, 0, 6'h00, 6'h0C, V_DEC, "sys_decode");
        for (int i = 0; i < 20; i++)
            cyc(1, 0, 6'h00, 6'h0C, V_HALT, "halt_hold");

        do_reset();

`ifdef MCTRL_PERF_EN
        // ADD (4 cycles), SW (4 cycles), J (2 cycles): 10 cycles, 3 retired.
        cyc(1, 0, 6'h00, 6'h20, V_FACC, "p_add_fetch");
        cyc(1, 0, 6'h00, 6'h20, V_DEC, "p_add_decode");
        cyc(1, 0, 6'h00, 6'h20, V_EX, "p_add_exec");
        cyc(1, 0, 6'h00, 6'h20, ev(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0), "p_add_wb");
        cyc(1, 0, 6'h2B, 6'h00, V_FACC, "p_sw_fetch");
        cyc(1, 0, 6'h2B, 6'h00, V_DEC, "p_sw_decode");
        cyc(1, 0, 6'h2B, 6'h00, V_EX, "p_sw_exec");
        cyc(1, 0, 6'h2B, 6'h00, ev(3'd3, 1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0), "p_sw_mem");
        cyc(1, 0, 6'h02, 6'h00, V_FACC, "p_j_fetch");
        cyc(1, 0, 6'h02, 6'h00, ev(3'd1, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 0), "p_j_decode");
        check("perf_cyc_cnt", cyc_cnt, 32'd10);
        check("perf_ret_cnt", ret_cnt, 32'd3);
`endif

        // Reset in the middle of a MEM wait. The access is abandoned.
        cyc(1, 0, 6'h23, 6'h00, V_FACC, "mr_fetch");
        cyc(1, 0, 6'h23, 6'h00, V_DEC, "mr_decode");
        cyc(1, 0, 6'h23, 6'h00, V_EX, "mr_exec");
        mem_ready = 1'b0;
        exp_q.push_back(ev(3'd3, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0));
        nm_q.push_back("mr_mem_wait");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_state", {29'd0, state}, 32'd0);
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
`ifdef MCTRL_PERF_EN
        check("midrst_cyc_cnt", cyc_cnt, 32'd0);
        check("midrst_ret_cnt", ret_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 6'h00, 6'h20, V_FACC, "post_rst_fetch");
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Upper bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
